// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS datapath arithmetic blocks.
// This package holds the divider FSM state encoding and the result constants.
package mips_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_e;

   localparam int unsigned DIV_WIDTH = 8;

   // Quotient reported when the divisor is zero.
   localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/div8bit_seq_sub9bit.sv
// Ripple-carry trial subtractor for the restoring divider.
// It computes a - b as a + ~b + 1. borrowOut is the inverted carry out of the top bit.
module SUB9bit #(
   parameter int unsigned N = 9
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] diff,
   output logic         borrowOut
);

   always_comb begin
      logic carry;
      logic nb;
      diff  = '0;
      carry = 1'b1;
      nb    = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         nb      = ~b[i];
         diff[i] = a[i] ^ nb ^ carry;
         carry   = (a[i] & nb) | (carry & (a[i] ^ nb));
      end
      borrowOut = ~carry;
   end

endmodule

// File: rtl/div8bit_seq.sv
// Multi-cycle unsigned restoring divider. It produces one quotient bit per clock.
// Results are returned through a start/busy/done handshake.
module div8bit_seq
   import mips_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             divByZero
);

   localparam int unsigned      PW        = WIDTH + 1;
   localparam int unsigned      CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] QUOT_DIV0 = {WIDTH{DIV0_QUOTIENT[0]}};

   div_state_e       state_q, state_d;
   logic [PW-1:0]    p_q, p_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] dvsr_q, dvsr_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;

   logic [PW-1:0]    p_shift;
   logic [PW-1:0]    trial_diff;
   logic             trial_borrow;

   // Shift P left and bring in the next dividend bit. The top bit of P is
   // always zero after a restore or a successful subtract, so it drops out.
   assign p_shift = PW'({p_q, q_q[WIDTH-1]});

   SUB9bit #(
      .N(PW)
   ) u_sub (
      .a        (p_shift),
      .b        ({1'b0, dvsr_q}),
      .diff     (trial_diff),
      .borrowOut(trial_borrow)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         p_q     <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
         dvsr_q  <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         dvsr_q  <= dvsr_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      dvsr_d  = dvsr_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               dvsr_d = divisor;
               p_d    = '0;
               q_d    = dividend;
               cnt_d  = '0;
               dbz_d  = 1'b0;
               if (divisor == '0) begin
                  state_d = DONE;
                  quot_d  = QUOT_DIV0;
                  rem_d   = dividend;
                  dbz_d   = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
         end

         RUN: begin
            p_d   = trial_borrow ? p_shift : trial_diff;
            q_d   = {q_q[WIDTH-2:0], ~trial_borrow};
            cnt_d = cnt_q + CW'(1);
            // The result registers load on the final iteration, so they are
            // already valid in the cycle where done is high.
            if (cnt_q == LAST_ITER) begin
               state_d = DONE;
               quot_d  = q_d;
               rem_d   = p_d[WIDTH-1:0];
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy      = (state_q == RUN);
   assign done      = (state_q == DONE);
   assign quotient  = quot_q;
   assign remainder = rem_q;
   assign divByZero = dbz_q;

endmodule

// File: tb/tb_div8bit_seq.sv
// Scoreboard bench for div8bit_seq. The driver queues expected results from plain
// arithmetic, and a monitor checks latency, busy and the results on every cycle.
module tb_div8bit_seq;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy, done, divByZero;
   logic [W-1:0] quotient, remainder;

   div8bit_seq #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .dividend (dividend),
      .divisor  (divisor),
      .busy     (busy),
      .done     (done),
      .quotient (quotient),
      .remainder(remainder),
      .divByZero(divByZero)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] a, b, q, r;
      logic         z;
      int           lat;
      int           t0;
   } exp_t;

   exp_t         sbq[$];
   logic [W-1:0] hold_q = '0;
   logic [W-1:0] hold_r = '0;
   logic         hold_z = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // The acceptance edge begins cycle 1, so the monitor numbers cycles from 1.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      @(posedge clk);
      #1;
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = W'($urandom);
      divisor  = W'($urandom);
      e.a   = a;
      e.b   = b;
      e.q   = (b == 0) ? {W{1'b1}} : W'(a / b);
      e.r   = (b == 0) ? a : W'(a % b);
      e.z   = (b == 0);
      e.lat = (b == 0) ? 1 : W + 1;
      e.t0  = cyc;
      sbq.push_back(e);
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
      int lat;
      lat = (b == 0) ? 1 : W + 1;
      issue(a, b);
      repeat (lat - 1) @(posedge clk);
   endtask

   always @(negedge clk) begin : mon
      int   idx;
      logic eb;
      exp_t e;
      if (rst_n) begin
         eb  = 1'b0;
         idx = 0;
         if (sbq.size() > 0) begin
            idx = cyc - sbq[0].t0 + 1;
            eb  = (sbq[0].b != 0) && (idx >= 1) && (idx <= W);
         end
         check("busy", {31'd0, busy}, {31'd0, eb});
         if (sbq.size() == 0) begin
            check("done_idle", {31'd0, done}, 32'd0);
            check("hold_quotient", {24'd0, quotient}, {24'd0, hold_q});
            check("hold_remainder", {24'd0, remainder}, {24'd0, hold_r});
            check("hold_divByZero", {31'd0, divByZero}, {31'd0, hold_z});
         end else if (done) begin
            e = sbq.pop_front();
            check("latency", idx, e.lat);
            check("quotient", {24'd0, quotient}, {24'd0, e.q});
            check("remainder", {24'd0, remainder}, {24'd0, e.r});
            check("divByZero", {31'd0, divByZero}, {31'd0, e.z});
            hold_q = e.q;
            hold_r = e.r;
            hold_z = e.z;
         end else if (idx >= sbq[0].lat) begin
            e = sbq.pop_front();
            total++;
            bad++;
            $display("FAIL done_timeout: no done by cycle %0d for %0d/%0d", idx, e.a, e.b);
            hold_q = e.q;
            hold_r = e.r;
            hold_z = e.z;
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : driver
      logic [W-1:0] a, b;

      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_quotient", {24'd0, quotient}, 32'd0);
      check("rst_remainder", {24'd0, remainder}, 32'd0);
      check("rst_divByZero", {31'd0, divByZero}, 32'd0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      run_op(8'd200, 8'd7);
      run_op(8'd255, 8'd1);
      run_op(8'd5, 8'd9);
      run_op(8'd17, 8'd0);
      run_op(8'd10, 8'd3);

      // A start during RUN must be ignored.
      issue(8'd100, 8'd10);
      repeat (3) @(posedge clk);
      #1;
      dividend = 8'd50;
      divisor  = 8'd5;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      run_op(8'd7, 8'd7);

      // An asynchronous reset in the middle of a division aborts it.
      issue(8'd123, 8'd4);
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      sbq.delete();
      hold_q = '0;
      hold_r = '0;
      hold_z = 1'b0;
      #1;
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      check("midrst_quotient", {24'd0, quotient}, 32'd0);
      check("midrst_remainder", {24'd0, remainder}, 32'd0);
      check("midrst_divByZero", {31'd0, divByZero}, 32'd0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (12) @(posedge clk);
      run_op(8'd9, 8'd2);

      run_op(8'd0, 8'd1);
      run_op(8'd0, 8'd0);
      run_op(8'd255, 8'd255);
      run_op(8'd254, 8'd255);
      run_op(8'd255, 8'd0);
      run_op(8'd128, 8'd2);
      run_op(8'd255, 8'd128);

      for (int i = 0; i < 1500; i++) begin
         a = W'($urandom_range(0, 255));
         if ($urandom_range(0, 15) == 0) b = '0;
         else if ($urandom_range(0, 3) == 0) b = W'($urandom_range(1, 15));
         else b = W'($urandom_range(1, 255));
         run_op(a, b);
      end

      repeat (4) @(posedge clk);
      check("scoreboard_empty", sbq.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
